pad_tx_seq: RTL and testbench
=============================

PAD_TX_SEQ -- requirements
Module: pad_tx_seq

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, frame width in bits.
REQ-002 The block SHALL have parameter DIV_W, default 8, width of bit-period divider input.
REQ-003 The block SHALL have parameter GUARD, default 2, lead/trail guard length in cycles; legal range 1..15.
REQ-004 The block SHALL have one clock and one reset: asynchronous, active-high reset.
REQ-005 The block SHALL have port CLK_I  input  1  sole clock; all flops on rising edge.
REQ-006 The block SHALL have port RST_I  input  1  asynchronous active-high reset.
REQ-007 The block SHALL have port DATA_I  input  DATA_W  frame data, transmitted LSB first.
REQ-008 The block SHALL have port VALID_I  input  1  frame request.
REQ-009 The block SHALL have port READY_O  output  1  block can accept a frame.
REQ-010 The block SHALL have port DIV_I  input  DIV_W  bit period = DIV_I+1 cycles.
REQ-011 The block SHALL have port OD_I  input  1  1 = open-drain mode (external pull-up supplies high), 0 = push-pull.
REQ-012 The block SHALL have port DS_I  input  2  pad drive-strength select.
REQ-013 The block SHALL have port DO_O  output  1  pad data-out.
REQ-014 The block SHALL have port OE_O  output  1  pad output enable.
REQ-015 The block SHALL have port DS_O  output  2  pad drive strength.
REQ-016 The block SHALL have port BUSY_O  output  1  frame in progress.
REQ-017 The block SHALL have port DONE_O  output  1  one-cycle frame-complete pulse.

Function
REQ-018 Accept SHALL occur on a rising edge with VALID_I=1 and READY_O=1; DATA_I, DIV_I, OD_I and DS_I SHALL be latched at accept; input changes after accept SHALL have no effect on the frame.
REQ-019 READY_O SHALL be 1 exactly when state is IDLE and RST_I=0.
REQ-020 States SHALL be IDLE -> LEAD (GUARD cycles) -> SHIFT (DATA_W bits, DIV+1 cycles each) -> TRAIL (GUARD cycles) -> IDLE; no other transitions except reset.
REQ-021 BUSY_O SHALL be 1 in LEAD, SHIFT and TRAIL; busy length SHALL be 2*GUARD + DATA_W*(DIV+1) cycles, starting the cycle after the accept edge.
REQ-022 Push-pull mode: OE_O=1 in LEAD/SHIFT/TRAIL; DO_O=1 in LEAD/TRAIL; DO_O=current bit in SHIFT.
REQ-023 Open-drain mode: DO_O=0 in all non-IDLE states; OE_O=1 only in SHIFT while the current bit is 0; OE_O=0 in LEAD/TRAIL.
REQ-024 In IDLE: OE_O=0 and DO_O=1 (pad released).
REQ-025 DO_O, OE_O and DS_O SHALL be driven directly from flops, with no combinational path from any input.
REQ-026 DS_O SHALL update to the latched DS_I on the cycle after accept and hold until the next accept.
REQ-027 DONE_O SHALL pulse high for exactly the first IDLE cycle after TRAIL.
REQ-028 Back-to-back: an accept in the DONE_O cycle SHALL be legal; push-pull OE_O SHALL then be low for exactly one cycle between frames.
REQ-029 Bit counter and divider SHALL not wrap; DIV_I = 2^DIV_W-1 SHALL yield a 2^DIV_W-cycle bit.
REQ-030 VALID_I while not IDLE SHALL be ignored; no queuing.

Reset
REQ-031 While RST_I=1, outputs SHALL be: state IDLE, OE_O=0, DO_O=1, DS_O=0, BUSY_O=0, DONE_O=0, READY_O=0; all registers cleared.
REQ-032 Reset asserted mid-frame SHALL release the pad immediately (asynchronously), abort the frame and produce no DONE_O.
REQ-033 READY_O SHALL be 1 in the first cycle after RST_I deasserts.

Verification
REQ-034 Push-pull, DATA=0xA5, DIV=1, GUARD=2 -> OE_O high 20 cycles; DO_O: 1,1, then bit sequence 1,0,1,0,0,1,0,1 each held 2 cycles, then 1,1; DONE_O in cycle 21 after accept.
REQ-035 Open-drain, DATA=0x0F, DIV=0 -> DO_O=0 throughout; OE_O: 0,0, then 0,0,0,0,1,1,1,1, then 0,0; DONE_O once.
REQ-036 VALID_I held high with two frames -> second accept coincides with DONE_O; OE_O low exactly one cycle between frames.
REQ-037 RST_I pulsed during SHIFT bit 3 -> OE_O=0, DO_O=1, BUSY_O=0 without waiting for a clock edge; no DONE_O; READY_O=1 the first cycle after release.
REQ-038 DIV=255, GUARD=2 -> BUSY_O high exactly 2052 cycles; each bit 256 cycles.
REQ-039 DATA_I, DIV_I, OD_I and DS_I toggled mid-frame -> pad waveform and DS_O unchanged.

Source files
------------

// File: rtl/pad_tx_seq_if.sv
// ---------------------------------------------------------------------------
// pad_tx_seq_if -- frame request and pad-control bundle for pad_tx_seq.
//   DATA_I  [DATA_W] frame data, sent LSB first
//   VALID_I          frame request
//   READY_O          sequencer can accept a frame
//   DIV_I   [DIV_W]  bit period = DIV_I+1 cycles
//   OD_I             1 = open-drain, 0 = push-pull
//   DS_I    [2]      drive-strength select
//   DO_O / OE_O      pad data-out / output enable
//   DS_O    [2]      pad drive strength
//   BUSY_O           frame in progress
//   DONE_O           one-cycle frame-complete pulse
// master: requester side; slave: the sequencer.
// ---------------------------------------------------------------------------
interface pad_tx_seq_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV_W  = 8
);
    logic [DATA_W-1:0] DATA_I;
    logic              VALID_I;
    logic              READY_O;
    logic [DIV_W-1:0]  DIV_I;
    logic              OD_I;
    logic [1:0]        DS_I;
    logic              DO_O;
    logic              OE_O;
    logic [1:0]        DS_O;
    logic              BUSY_O;
    logic              DONE_O;

    modport master (
        output DATA_I, VALID_I, DIV_I, OD_I, DS_I,
        input  READY_O, DO_O, OE_O, DS_O, BUSY_O, DONE_O
    );

    modport slave (
        input  DATA_I, VALID_I, DIV_I, OD_I, DS_I,
        output READY_O, DO_O, OE_O, DS_O, BUSY_O, DONE_O
    );
endinterface

// File: rtl/pad_tx_seq.sv
// ---------------------------------------------------------------------------
// pad_tx_seq -- serialises one DATA_W-bit frame onto a pad, framed by GUARD
// cycles of lead and trail, in push-pull or open-drain signalling.
//   CLK_I  sole clock, rising edge
//   RST_I  asynchronous active-high reset
//   bus    pad_tx_seq_if.slave (request inputs, pad/status outputs)
// ---------------------------------------------------------------------------
module pad_tx_seq #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV_W  = 8,
    parameter int unsigned GUARD  = 2
) (
    input  logic         CLK_I,
    input  logic         RST_I,
    pad_tx_seq_if.slave  bus
);
    localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    if (GUARD < 1 || GUARD > 15) begin : g_guard_range
        $error("pad_tx_seq: GUARD must be in 1..15");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT,
        ST_TRAIL
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [3:0]        r_gcnt, w_gcnt_nxt;     // guard cycle counter
    logic [DIV_W-1:0]  r_dcnt, w_dcnt_nxt;     // cycles within current bit
    logic [BW-1:0]     r_bcnt, w_bcnt_nxt;     // bit index
    logic [DATA_W-1:0] r_sh,   w_sh_nxt;       // bit 0 is the bit on the pad
    logic [DIV_W-1:0]  r_div,  w_div_nxt;
    logic              r_od,   w_od_nxt;
    logic [1:0]        r_ds,   w_ds_nxt;
    logic              r_done, w_done_nxt;
    logic              r_do,   w_do_nxt;
    logic              r_oe,   w_oe_nxt;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gcnt_nxt  = r_gcnt;
        w_dcnt_nxt  = r_dcnt;
        w_bcnt_nxt  = r_bcnt;
        w_sh_nxt    = r_sh;
        w_div_nxt   = r_div;
        w_od_nxt    = r_od;
        w_ds_nxt    = r_ds;
        w_done_nxt  = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.VALID_I) begin
                    w_state_nxt = ST_LEAD;
                    w_gcnt_nxt  = '0;
                    w_sh_nxt    = bus.DATA_I;
                    w_div_nxt   = bus.DIV_I;
                    w_od_nxt    = bus.OD_I;
                    w_ds_nxt    = bus.DS_I;
                end
            end
            ST_LEAD: begin
                if (r_gcnt == 4'(GUARD - 1)) begin
                    w_state_nxt = ST_SHIFT;
                    w_dcnt_nxt  = '0;
                    w_bcnt_nxt  = '0;
                end else begin
                    w_gcnt_nxt = r_gcnt + 4'd1;
                end
            end
            ST_SHIFT: begin
                // Equality compare against the latched divider, so an
                // all-ones DIV never needs a wrapping counter.
                if (r_dcnt == r_div) begin
                    w_dcnt_nxt = '0;
                    if (r_bcnt == BW'(DATA_W - 1)) begin
                        w_state_nxt = ST_TRAIL;
                        w_gcnt_nxt  = '0;
                    end else begin
                        w_bcnt_nxt = r_bcnt + 1'b1;
                        w_sh_nxt   = r_sh >> 1;
                    end
                end else begin
                    w_dcnt_nxt = r_dcnt + 1'b1;
                end
            end
            ST_TRAIL: begin
                if (r_gcnt == 4'(GUARD - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_gcnt_nxt = r_gcnt + 4'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Pad outputs are decoded from next-state values and registered,
        // so the pad follows the state with no input-to-output path.
        w_do_nxt = 1'b1;
        w_oe_nxt = 1'b0;
        if (w_state_nxt == ST_SHIFT) begin
            if (w_od_nxt) begin
                w_do_nxt = 1'b0;
                w_oe_nxt = ~w_sh_nxt[0];
            end else begin
                w_do_nxt = w_sh_nxt[0];
                w_oe_nxt = 1'b1;
            end
        end else if (w_state_nxt != ST_IDLE) begin
            w_do_nxt = ~w_od_nxt;
            w_oe_nxt = ~w_od_nxt;
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_gcnt <= '0;
            r_dcnt <= '0;
            r_bcnt <= '0;
            r_sh   <= '0;
            r_div  <= '0;
            r_od   <= 1'b0;
            r_ds   <= '0;
            r_done <= 1'b0;
            r_do   <= 1'b1;
            r_oe   <= 1'b0;
        end else begin
            r_gcnt <= w_gcnt_nxt;
            r_dcnt <= w_dcnt_nxt;
            r_bcnt <= w_bcnt_nxt;
            r_sh   <= w_sh_nxt;
            r_div  <= w_div_nxt;
            r_od   <= w_od_nxt;
            r_ds   <= w_ds_nxt;
            r_done <= w_done_nxt;
            r_do   <= w_do_nxt;
            r_oe   <= w_oe_nxt;
        end
    end

    assign bus.READY_O = (r_state == ST_IDLE) && !RST_I;
    assign bus.BUSY_O  = (r_state != ST_IDLE);
    assign bus.DONE_O  = r_done;
    assign bus.DO_O    = r_do;
    assign bus.OE_O    = r_oe;
    assign bus.DS_O    = r_ds;
endmodule

// File: tb/tb_pad_tx_seq.sv
// ---------------------------------------------------------------------------
// tb_pad_tx_seq -- directed bench for pad_tx_seq (DATA_W=8, DIV_W=8, GUARD=2).
// Inputs change and outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_pad_tx_seq;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    pad_tx_seq_if #(.DATA_W(8), .DIV_W(8)) bus ();

    pad_tx_seq #(.DATA_W(8), .DIV_W(8), .GUARD(2)) dut (
        .CLK_I (clk),
        .RST_I (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    endtask

    initial begin
        logic [19:0] exp_a;
        logic [11:0] exp_b;
        logic [11:0] exp_c1;
        logic [11:0] exp_c2;
        int          done_cnt;
        int          oe_low;
        int          busy_cnt;
        int          done_at;

        n_pass  = 0;
        n_total = 0;
        exp_a   = 20'b11110011000011001111;  // 0xA5, DIV=1
        exp_b   = 12'b000000111100;          // OE for 0x0F open-drain
        exp_c1  = 12'b110011110011;          // 0x3C, DIV=0
        exp_c2  = 12'b111000000111;          // 0x81, DIV=0

        rst         = 1'b0;
        bus.VALID_I = 1'b0;
        bus.DATA_I  = '0;
        bus.DIV_I   = '0;
        bus.OD_I    = 1'b0;
        bus.DS_I    = '0;
        #2 rst = 1'b1;
        #1;

        // ---------------- reset state
        chk("rst_oe",    bus.OE_O,    0);
        chk("rst_do",    bus.DO_O,    1);
        chk("rst_ds",    bus.DS_O,    0);
        chk("rst_busy",  bus.BUSY_O,  0);
        chk("rst_done",  bus.DONE_O,  0);
        chk("rst_ready", bus.READY_O, 0);
        tick();
        tick();
        chk("rst_ready_held", bus.READY_O, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_release", bus.READY_O, 1);
        tick();

        // ---------------- push-pull 0xA5, DIV=1, inputs disturbed mid-frame
        bus.VALID_I = 1'b1;
        bus.DATA_I  = 8'hA5;
        bus.DIV_I   = 8'd1;
        bus.OD_I    = 1'b0;
        bus.DS_I    = 2'd2;
        tick();
        bus.VALID_I = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            chk($sformatf("a_do_c%0d", i),    bus.DO_O,    exp_a[20-i]);
            chk($sformatf("a_oe_c%0d", i),    bus.OE_O,    1);
            chk($sformatf("a_busy_c%0d", i),  bus.BUSY_O,  1);
            chk($sformatf("a_done_c%0d", i),  bus.DONE_O,  0);
            chk($sformatf("a_ready_c%0d", i), bus.READY_O, 0);
            chk($sformatf("a_ds_c%0d", i),    bus.DS_O,    2);
            if (i == 3) begin
                bus.DATA_I = 8'h00;
                bus.DIV_I  = 8'd5;
                bus.OD_I   = 1'b1;
                bus.DS_I   = 2'd1;
            end
            if (i == 6)  bus.VALID_I = 1'b1;
            if (i == 10) bus.VALID_I = 1'b0;
            tick();
        end
        chk("a_done_c21",  bus.DONE_O,  1);
        chk("a_oe_c21",    bus.OE_O,    0);
        chk("a_do_c21",    bus.DO_O,    1);
        chk("a_busy_c21",  bus.BUSY_O,  0);
        chk("a_ready_c21", bus.READY_O, 1);
        tick();
        chk("a_done_c22",  bus.DONE_O,  0);
        chk("a_ds_hold",   bus.DS_O,    2);

        // ---------------- open-drain 0x0F, DIV=0
        bus.VALID_I = 1'b1;
        bus.DATA_I  = 8'h0F;
        bus.DIV_I   = 8'd0;
        bus.OD_I    = 1'b1;
        bus.DS_I    = 2'd3;
        tick();
        bus.VALID_I = 1'b0;
        done_cnt = 0;
        for (int i = 1; i <= 14; i++) begin
            if (bus.DONE_O === 1'b1) done_cnt++;
            if (i <= 12) begin
                chk($sformatf("b_do_c%0d", i),   bus.DO_O,   0);
                chk($sformatf("b_oe_c%0d", i),   bus.OE_O,   exp_b[12-i]);
                chk($sformatf("b_busy_c%0d", i), bus.BUSY_O, 1);
            end else begin
                chk($sformatf("b_do_c%0d", i),   bus.DO_O,   1);
                chk($sformatf("b_oe_c%0d", i),   bus.OE_O,   0);
                chk($sformatf("b_busy_c%0d", i), bus.BUSY_O, 0);
            end
            if (i == 13) chk("b_done_c13", bus.DONE_O, 1);
            tick();
        end
        chk("b_done_count", done_cnt, 1);
        chk("b_ds",         bus.DS_O, 3);

        // ---------------- back-to-back push-pull, VALID held high
        bus.VALID_I = 1'b1;
        bus.DATA_I  = 8'h3C;
        bus.DIV_I   = 8'd0;
        bus.OD_I    = 1'b0;
        bus.DS_I    = 2'd1;
        tick();
        bus.DATA_I = 8'h81;
        oe_low = 0;
        for (int i = 1; i <= 25; i++) begin
            if (bus.OE_O !== 1'b1) oe_low++;
            if (i <= 12) begin
                chk($sformatf("c1_do_c%0d", i), bus.DO_O, exp_c1[12-i]);
                chk($sformatf("c1_oe_c%0d", i), bus.OE_O, 1);
            end else if (i == 13) begin
                chk("c_gap_oe",    bus.OE_O,    0);
                chk("c_gap_done",  bus.DONE_O,  1);
                chk("c_gap_ready", bus.READY_O, 1);
                chk("c_gap_busy",  bus.BUSY_O,  0);
            end else begin
                chk($sformatf("c2_do_c%0d", i),   bus.DO_O,   exp_c2[25-i]);
                chk($sformatf("c2_oe_c%0d", i),   bus.OE_O,   1);
                chk($sformatf("c2_busy_c%0d", i), bus.BUSY_O, 1);
                bus.VALID_I = 1'b0;
            end
            tick();
        end
        chk("c_oe_low_cycles", oe_low, 1);
        chk("c2_done",    bus.DONE_O, 1);
        chk("c2_done_oe", bus.OE_O,   0);
        tick();
        chk("c_after_busy", bus.BUSY_O, 0);
        chk("c_after_done", bus.DONE_O, 0);

        // ---------------- reset during SHIFT bit 3
        bus.VALID_I = 1'b1;
        bus.DATA_I  = 8'h00;
        bus.DIV_I   = 8'd3;
        bus.OD_I    = 1'b0;
        bus.DS_I    = 2'd2;
        tick();
        bus.VALID_I = 1'b0;
        repeat (15) tick();
        chk("d_pre_do",   bus.DO_O,   0);
        chk("d_pre_oe",   bus.OE_O,   1);
        chk("d_pre_busy", bus.BUSY_O, 1);
        rst = 1'b1;
        #1;
        chk("d_async_oe",    bus.OE_O,    0);
        chk("d_async_do",    bus.DO_O,    1);
        chk("d_async_busy",  bus.BUSY_O,  0);
        chk("d_async_ready", bus.READY_O, 0);
        chk("d_async_ds",    bus.DS_O,    0);
        done_cnt = 0;
        repeat (3) begin
            tick();
            if (bus.DONE_O !== 1'b0) done_cnt++;
        end
        rst = 1'b0;
        #1;
        chk("d_ready_release", bus.READY_O, 1);
        repeat (20) begin
            tick();
            if (bus.DONE_O !== 1'b0) done_cnt++;
        end
        chk("d_no_done", done_cnt,   0);
        chk("d_idle",    bus.BUSY_O, 0);

        // ---------------- DIV=255 long bits, push-pull 0xAA
        bus.VALID_I = 1'b1;
        bus.DATA_I  = 8'hAA;
        bus.DIV_I   = 8'd255;
        bus.OD_I    = 1'b0;
        bus.DS_I    = 2'd0;
        tick();
        bus.VALID_I = 1'b0;
        busy_cnt = 0;
        done_at  = 0;
        for (int c = 1; c <= 2060; c++) begin
            if (bus.BUSY_O === 1'b1) busy_cnt++;
            if (bus.DONE_O === 1'b1 && done_at == 0) done_at = c;
            case (c)
                2:    chk("e_do_lead_end",   bus.DO_O, 1);
                3:    chk("e_do_bit0_start", bus.DO_O, 0);
                258:  chk("e_do_bit0_end",   bus.DO_O, 0);
                259:  chk("e_do_bit1_start", bus.DO_O, 1);
                1794: chk("e_do_bit6_end",   bus.DO_O, 0);
                1795: chk("e_do_bit7_start", bus.DO_O, 1);
                2052: chk("e_do_trail_end",  bus.DO_O, 1);
                default: ;
            endcase
            tick();
        end
        chk("e_busy_len", busy_cnt, 2052);
        chk("e_done_at",  done_at,  2053);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
